ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, then
// shifts one byte plus odd parity out on device-generated clock falls and checks the ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   output logic       rx_inhibit,
   input  logic       ps2_clock_in,
   input  logic       ps2_data_in,
   output logic       ps2_clock_oe,
   output logic       ps2_data_oe,
   output logic [3:0] state_dbg
);

   localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_SEND,
      S_STOP,
      S_ACK,
      S_WAIT_IDLE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t          state;
   logic [8:0]      shift_reg;
   logic [3:0]      bit_cnt;
   logic [IW-1:0]   inh_cnt;
   logic [TW-1:0]   to_cnt;
   logic            clk_s1, clk_sync, clk_prev;
   logic            dat_s1, dat_sync;
   logic            fall, timed, timeout;

   assign state_dbg = state;
   assign fall      = clk_prev & ~clk_sync;
   assign timed     = (state == S_SEND) || (state == S_STOP) ||
                      (state == S_ACK)  || (state == S_WAIT_IDLE);
   assign timeout   = (to_cnt == TO_LAST);

   // Pads idle high, so the synchronizers reset to 1 to avoid a phantom fall.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         clk_s1   <= 1'b1;
         clk_sync <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_s1   <= ps2_clock_in;
         clk_sync <= clk_s1;
         clk_prev <= clk_sync;
         dat_s1   <= ps2_data_in;
         dat_sync <= dat_s1;
      end
   end

   // Handshake: a byte is taken on any edge where tx_start and tx_ready are both
   // high; tx_start while tx_ready is low is dropped, never queued.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state        <= S_IDLE;
         tx_ready     <= 1'b1;
         tx_done      <= 1'b0;
         tx_error     <= 1'b0;
         rx_inhibit   <= 1'b0;
         ps2_clock_oe <= 1'b0;
         ps2_data_oe  <= 1'b0;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         inh_cnt      <= '0;
         to_cnt       <= '0;
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         if (timed) to_cnt <= to_cnt + 1'b1;
         if (timed && timeout) begin
            state       <= S_ERROR;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (tx_start) begin
                     shift_reg    <= {~^tx_data, tx_data};
                     state        <= S_INHIBIT;
                     ps2_clock_oe <= 1'b1;
                     tx_ready     <= 1'b0;
                     rx_inhibit   <= 1'b1;
                     inh_cnt      <= '0;
                  end
               end
               S_INHIBIT: begin
                  if (inh_cnt == INH_LAST) begin
                     state       <= S_RTS;
                     ps2_data_oe <= 1'b1;
                  end else begin
                     inh_cnt <= inh_cnt + 1'b1;
                  end
               end
               S_RTS: begin
                  state        <= S_SEND;
                  ps2_clock_oe <= 1'b0;
                  to_cnt       <= '0;
                  bit_cnt      <= '0;
               end
               S_SEND: begin
                  // Falls 1..9 carry d0..d7 then parity, LSB first.
                  if (fall) begin
                     ps2_data_oe <= ~shift_reg[0];
                     shift_reg   <= {1'b0, shift_reg[8:1]};
                     bit_cnt     <= bit_cnt + 1'b1;
                     if (bit_cnt == 4'd8) state <= S_STOP;
                  end
               end
               S_STOP: begin
                  if (fall) begin
                     ps2_data_oe <= 1'b0;
                     bit_cnt     <= bit_cnt + 1'b1;
                     state       <= S_ACK;
                  end
               end
               S_ACK: begin
                  if (fall) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (dat_sync) begin
                        state    <= S_ERROR;
                        tx_error <= 1'b1;
                     end else begin
                        state <= S_WAIT_IDLE;
                     end
                  end
               end
               S_WAIT_IDLE: begin
                  if (clk_sync && dat_sync) begin
                     state   <= S_DONE;
                     tx_done <= 1'b1;
                  end
               end
               S_DONE, S_ERROR: begin
                  state      <= S_IDLE;
                  tx_ready   <= 1'b1;
                  rx_inhibit <= 1'b0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain PS/2 keyboard model, frame and outcome
// scoreboards fed from a byte-level reference model.
module tb_ps2_host_tx;

   localparam int INH = 10;
   localparam int TMO = 2000;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_ready, tx_done, tx_error, rx_inhibit;
   logic       ps2_clock_oe, ps2_data_oe;
   logic       ps2_clock_in, ps2_data_in;
   logic [3:0] state_dbg;
   logic       dev_clk_low, dev_data_low;

   // Wired-AND bus: either side pulling low wins.
   assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
   assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clock        (clk),
      .resetn       (resetn),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .tx_ready     (tx_ready),
      .tx_done      (tx_done),
      .tx_error     (tx_error),
      .rx_inhibit   (rx_inhibit),
      .ps2_clock_in (ps2_clock_in),
      .ps2_data_in  (ps2_data_in),
      .ps2_clock_oe (ps2_clock_oe),
      .ps2_data_oe  (ps2_data_oe),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [10:0] exp_q[$];
   logic [1:0]  res_q[$];
   logic [1:0]  res_e;
   logic [10:0] exp_f;
   logic [10:0] dev_frame;
   int          start_cyc = 0, rise_cyc = 0, rel_cyc = 0, drise_cyc = 0, done_cyc = 0;
   bit          in_frame = 1'b0;
   int          ready_viol = 0;
   bit          expect_timeout = 1'b0;
   int          dev_mode = 0;
   bit          dev_abort = 1'b0;
   bit          dev_busy = 1'b0;
   int          dev_fall = 0;
   logic        prev_clk_oe = 1'b0, prev_dat_oe = 1'b0;
   logic [7:0]  rnd_byte;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference frame as the device sees it: start, d0..d7, odd parity, stop.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic [10:0] f;
      int ones;
      ones = $countones(d);
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
      f[9]  = (ones % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   // ---------------- device model ----------------
   // mode 0: 11 clocks, ACK low; mode 1: 11 clocks, no ACK; mode 2: silent.
   initial begin : device
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      forever begin
         @(negedge clk);
         if (resetn && dev_mode != 2 && !dev_busy && !ps2_clock_oe && ps2_data_oe) begin
            dev_busy     = 1'b1;
            dev_frame    = '0;
            dev_frame[0] = ps2_data_in;
            repeat (10) @(negedge clk);
            for (int k = 1; k <= 11; k++) begin
               dev_fall    = k;
               dev_clk_low = 1'b1;
               repeat (20) @(negedge clk);
               dev_clk_low = 1'b0;
               @(negedge clk);
               if (k <= 10) dev_frame[k] = ps2_data_in;
               if (k == 10 && dev_mode == 0) begin
                  repeat (9) @(negedge clk);
                  dev_data_low = 1'b1;
                  repeat (10) @(negedge clk);
               end else if (k == 11) begin
                  repeat (4) @(negedge clk);
                  dev_data_low = 1'b0;
               end else begin
                  repeat (19) @(negedge clk);
               end
            end
            if (dev_abort) begin
               dev_abort = 1'b0;
            end else begin
               check("frame_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  exp_f = exp_q.pop_front();
                  check("frame_bits", dev_frame, exp_f);
               end
            end
            dev_fall = 0;
            dev_busy = 1'b0;
         end
      end
   end

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      if (resetn) begin
         if (in_frame && tx_ready) ready_viol++;
         if (ps2_data_oe && !prev_dat_oe && ps2_clock_oe) drise_cyc = cyc;
         if (ps2_clock_oe && !prev_clk_oe) begin
            rise_cyc = cyc;
            check("accept_latency", cyc - start_cyc, 1);
            check("busy_flags", {tx_ready, rx_inhibit}, 2'b01);
         end
         if (!ps2_clock_oe && prev_clk_oe) begin
            rel_cyc = cyc;
            check("clock_oe_width", cyc - rise_cyc, INH + 1);
            check("start_bit_lead", cyc - drise_cyc, 1);
         end
         if (tx_done || tx_error) begin
            check("result_pending", res_q.size() > 0, 1);
            if (res_q.size() > 0) begin
               res_e = res_q.pop_front();
               check("outcome", {tx_error, tx_done}, res_e);
            end
            check("lines_released", {ps2_clock_oe, ps2_data_oe}, 0);
            if (tx_error && expect_timeout) check("timeout_latency", cyc - rel_cyc, TMO);
            check("ready_low_in_frame", ready_viol, 0);
            ready_viol = 0;
            in_frame   = 1'b0;
            done_cyc   = cyc;
         end
      end
      prev_clk_oe = ps2_clock_oe;
      prev_dat_oe = ps2_data_oe;
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] d);
      int guard;
      guard = 0;
      while (!tx_ready && guard < 6000) begin
         @(negedge clk);
         guard++;
      end
      check("ready_before_start", tx_ready, 1);
      tx_data  = d;
      tx_start = 1'b1;
      start_cyc = cyc;
      if (dev_mode != 2) exp_q.push_back(frame_of(d));
      res_q.push_back(dev_mode == 0 ? 2'b01 : 2'b10);
      expect_timeout = (dev_mode == 2);
      @(negedge clk);
      tx_start   = 1'b0;
      tx_data    = ~d;
      ready_viol = 0;
      in_frame   = 1'b1;
   endtask

   task automatic wait_result();
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!(tx_done || tx_error) && guard < 4000);
      if (!(tx_done || tx_error)) $display("no result, state_dbg=%0d", state_dbg);
      check("result_seen", tx_done | tx_error, 1);
   endtask

   task automatic wait_dev_idle();
      int guard;
      guard = 0;
      while (dev_busy && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("device_idle", dev_busy, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_dev_fall(input int n);
      int guard;
      guard = 0;
      while (dev_fall != n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("device_fall_reached", dev_fall, n);
   endtask

   // ---------------- stimulus ----------------
   initial begin : stimulus
      resetn   = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_ready", tx_ready, 1);
      check("reset_pulses", {tx_done, tx_error}, 0);
      check("reset_inhibit", rx_inhibit, 0);
      check("reset_oe", {ps2_clock_oe, ps2_data_oe}, 0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      dev_mode = 0;
      send_byte(8'hED); wait_result(); wait_dev_idle();
      send_byte(8'hF4); wait_result(); wait_dev_idle();

      dev_mode = 1;
      send_byte(8'hA6); wait_result(); wait_dev_idle();
      check("nack_idle_ready", tx_ready, 1);

      dev_mode = 2;
      send_byte(8'h3C); wait_result();
      repeat (2) @(negedge clk);
      check("timeout_idle", {tx_ready, ps2_clock_oe, ps2_data_oe}, 3'b100);
      dev_mode = 0;
      repeat (5) @(negedge clk);

      // Start request during a frame must be dropped.
      send_byte(8'h81);
      wait_dev_fall(3);
      tx_data  = 8'h55;
      tx_start = 1'b1;
      check("ready_low_midframe", tx_ready, 0);
      @(negedge clk);
      tx_start = 1'b0;
      wait_result(); wait_dev_idle();

      // Reset in the middle of bit 4.
      send_byte(8'h9A);
      wait_dev_fall(5);
      repeat (6) @(negedge clk);
      resetn = 1'b0;
      void'(res_q.pop_back());
      void'(exp_q.pop_back());
      dev_abort = 1'b1;
      in_frame  = 1'b0;
      @(negedge clk);
      check("abort_oe", {ps2_clock_oe, ps2_data_oe}, 0);
      check("abort_ready", {tx_ready, rx_inhibit}, 2'b10);
      check("abort_pulses", {tx_done, tx_error}, 0);
      resetn = 1'b1;
      wait_dev_idle();
      repeat (20) @(negedge clk);

      // Back-to-back frames.
      send_byte(8'hED); wait_result();
      send_byte(8'h02);
      check("b2b_accept", start_cyc - done_cyc, 1);
      wait_result(); wait_dev_idle();

      for (int i = 0; i < 6; i++) begin
         rnd_byte = 8'($urandom_range(0, 255));
         dev_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
         send_byte(rnd_byte); wait_result(); wait_dev_idle();
         repeat ($urandom_range(1, 8)) @(negedge clk);
      end

      repeat (20) @(negedge clk);
      check("frames_outstanding", exp_q.size(), 0);
      check("results_outstanding", res_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #(80000 * 10);
      $display("FAIL watchdog: cycle budget exceeded at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
